// File: rtl/ins_fetch_pkg.sv
// rtl/ins_fetch_pkg.sv - shared defaults and FSM state type for the instruction fetch unit
package ins_fetch_pkg;

  localparam int INS_AW_DEFAULT       = 10;
  localparam int INS_RESET_PC_DEFAULT = 0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ins_fetch_fifo.sv
// rtl/ins_fetch_fifo.sv - first-word-fall-through prefetch buffer with synchronous flush
module ins_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_q[PW-1:0]];
  assign count = wr_q - rd_q;
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ins_fetch_unit.sv
// rtl/ins_fetch_unit.sv - credit-based instruction prefetcher with redirect and FWFT output buffer
module ins_fetch_unit
  import ins_fetch_pkg::*;
#(
  parameter int AW       = INS_AW_DEFAULT,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = INS_RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  output logic [AW-1:0] mem_address,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic          mem_clken,
  input  logic [31:0]   mem_readdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr_data,
  output logic [AW+1:0] instr_pc,
  input  logic          redirect_valid,
  input  logic [AW+1:0] redirect_pc,
  output logic          busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 32 + AW;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] infl_pc_q;
  logic          infl_v_q;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   outstanding;
  logic          fifo_full, fifo_empty, push, pop;
  logic [DW-1:0] fifo_rdata;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Buffered plus in-flight words must never exceed DEPTH, so a push always has room.
  assign outstanding    = {1'b0, fifo_count} + {{CW{1'b0}}, infl_v_q};
  assign mem_chipselect = (state_q == FETCH) && (outstanding < (CW+1)'(DEPTH)) && !redirect_valid;
  assign mem_address    = pc_q;
  assign mem_write      = 1'b0;
  assign mem_clken      = 1'b1;

  assign push = infl_v_q & ~redirect_valid & ~fifo_full;
  assign pop  = instr_valid & instr_ready & ~redirect_valid;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && run)
      state_d = FETCH;
    else if (state_q == FETCH && !run)
      state_d = IDLE;

    pc_d = pc_q;
    if (redirect_valid)
      pc_d = redirect_pc[AW+1:2];
    else if (mem_chipselect)
      pc_d = pc_q + 1'b1;
  end

  // mem_chipselect is low during a redirect, so the in-flight slot clears on that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= AW'(RESET_PC);
      infl_v_q  <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_v_q  <= mem_chipselect;
      infl_pc_q <= pc_q;
    end
  end

  ins_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({infl_pc_q, mem_readdata}),
    .pop     (pop),
    .flush   (redirect_valid),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign instr_valid = ~fifo_empty;
  assign instr_data  = fifo_empty ? 32'h0 : fifo_rdata[31:0];
  assign instr_pc    = fifo_empty ? '0 : {fifo_rdata[DW-1:32], 2'b00};
  assign busy        = (state_q == FETCH) | infl_v_q;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb/tb_ins_fetch_unit.sv - directed self-checking bench for ins_fetch_unit
module tb_ins_fetch_unit;

  localparam int AW = 10;

  logic          clk;
  logic          reset_n;
  logic          run;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_write;
  logic          mem_clken;
  logic [31:0]   mem_readdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic [AW+1:0] instr_pc;
  logic          redirect_valid;
  logic [AW+1:0] redirect_pc;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [1024];

  ins_fetch_unit #(.AW(AW), .DEPTH(4), .RESET_PC(0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
  end

  always @(posedge clk) mem_readdata <= mem[mem_address];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n        = 1'b0;
    run            = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n        = 1'b0;
    run            = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();
    n_checks++;
    if ({mem_chipselect, instr_valid, busy} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_ctrl got cs/valid/busy=%b want 000", {mem_chipselect, instr_valid, busy});
    end
    n_checks++;
    if (instr_data !== 32'h0 || instr_pc !== 12'h0) begin
      n_errors++;
      $display("FAIL reset_data got data=%h pc=%h want 0/0", instr_data, instr_pc);
    end
    n_checks++;
    if (mem_address !== 10'd0 || mem_write !== 1'b0 || mem_clken !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mem got addr=%0d wr=%b clken=%b want 0/0/1", mem_address, mem_write, mem_clken);
    end
    run = 1'b0;
  endtask

  task automatic test_stream;
    do_reset();
    run = 1'b1;
    instr_ready = 1'b1;
    tick();
    n_checks++;
    if (mem_chipselect !== 1'b1 || mem_address !== 10'd0 || instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_entry got cs=%b addr=%0d valid=%b want 1/0/0", mem_chipselect, mem_address, instr_valid);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_latency1 got valid=%b want 0", instr_valid);
    end
    for (int k = 0; k < 8; k++) begin
      if (k != 0 || 1'b1) tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_data !== 32'(k) || instr_pc !== 12'(4 * k)) begin
        n_errors++;
        $display("FAIL stream_word%0d got v=%b d=%h pc=%h want 1/%h/%h", k, instr_valid, instr_data, instr_pc, k, 4 * k);
      end
    end
  endtask

  task automatic test_backpressure;
    int cs_cnt;
    do_reset();
    run = 1'b1;
    instr_ready = 1'b0;
    cs_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_chipselect) cs_cnt++;
    end
    n_checks++;
    if (cs_cnt !== 4) begin
      n_errors++;
      $display("FAIL bp_requests got %0d want 4", cs_cnt);
    end
    n_checks++;
    if (mem_chipselect !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_stalled got cs=%b busy=%b want 0/1", mem_chipselect, busy);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_data !== 32'(k) || instr_pc !== 12'(4 * k)) begin
        n_errors++;
        $display("FAIL bp_word%0d got v=%b d=%h pc=%h want 1/%h/%h", k, instr_valid, instr_data, instr_pc, k, 4 * k);
      end
    end
  endtask

  task automatic test_redirect;
    do_reset();
    run = 1'b1;
    instr_ready = 1'b0;
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h100;
    #1;
    n_checks++;
    if (mem_chipselect !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_cs_during got %b want 0", mem_chipselect);
    end
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 10'h40) begin
      n_errors++;
      $display("FAIL redir_after got v=%b cs=%b addr=%h want 0/1/040", instr_valid, mem_chipselect, mem_address);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_stale got valid=%b pc=%h want 0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_data !== 32'(8'h40 + k) || instr_pc !== 12'(12'h100 + 4 * k)) begin
        n_errors++;
        $display("FAIL redir_word%0d got v=%b d=%h pc=%h want 1/%h/%h", k, instr_valid, instr_data, instr_pc, 8'h40 + k, 12'h100 + 4 * k);
      end
    end
  endtask

  task automatic test_wrap;
    logic [11:0] exp_pc [4];
    logic [31:0] exp_d  [4];
    exp_pc = '{12'hFF8, 12'hFFC, 12'h000, 12'h004};
    exp_d  = '{32'd1022, 32'd1023, 32'd0, 32'd1};
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 12'hFF8;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (mem_address !== 10'd1022 || mem_chipselect !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_idle_load got addr=%0d cs=%b busy=%b want 1022/0/0", mem_address, mem_chipselect, busy);
    end
    run = 1'b1;
    instr_ready = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k] || instr_data !== exp_d[k]) begin
        n_errors++;
        $display("FAIL wrap_word%0d got v=%b d=%h pc=%h want 1/%h/%h", k, instr_valid, instr_data, instr_pc, exp_d[k], exp_pc[k]);
      end
    end
  endtask

  task automatic test_run_stop;
    do_reset();
    run = 1'b1;
    instr_ready = 1'b1;
    repeat (4) tick();
    run = 1'b0;
    tick();
    n_checks++;
    if (mem_chipselect !== 1'b0 || busy !== 1'b1 || instr_data !== 32'd2) begin
      n_errors++;
      $display("FAIL stop_e1 got cs=%b busy=%b d=%h want 0/1/2", mem_chipselect, busy, instr_data);
    end
    tick();
    n_checks++;
    if (mem_chipselect !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b1 || instr_data !== 32'd3) begin
      n_errors++;
      $display("FAIL stop_e2 got cs=%b busy=%b v=%b d=%h want 0/0/1/3", mem_chipselect, busy, instr_valid, instr_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (mem_chipselect !== 1'b0 || instr_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL stop_quiet%0d got cs=%b v=%b want 0/0", i, mem_chipselect, instr_valid);
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    run = 1'b1;
    instr_ready = 1'b1;
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_chipselect, instr_valid, busy} !== 3'b000 || instr_data !== 32'h0 || instr_pc !== 12'h0 || mem_address !== 10'd0) begin
      n_errors++;
      $display("FAIL areset_now got cs/v/busy=%b d=%h pc=%h addr=%0d want 000/0/0/0", {mem_chipselect, instr_valid, busy}, instr_data, instr_pc, mem_address);
    end
    tick();
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (mem_chipselect !== 1'b0) begin
      n_errors++;
      $display("FAIL areset_release_cs got %b want 0", mem_chipselect);
    end
    tick();
    n_checks++;
    if (mem_chipselect !== 1'b1 || mem_address !== 10'd0) begin
      n_errors++;
      $display("FAIL areset_restart got cs=%b addr=%0d want 1/0", mem_chipselect, mem_address);
    end
    repeat (2) tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 12'h0 || instr_data !== 32'd0) begin
      n_errors++;
      $display("FAIL areset_first got v=%b d=%h pc=%h want 1/0/0", instr_valid, instr_data, instr_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_run_stop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
